// File: rtl/insmem_stream.sv
// insmem_stream: MIPS fetch-stage instruction memory with a streaming loader.
//  - Loader: ready/valid word stream into an auto-incrementing pointer, range-checked per session.
//  - Fetch: registered, byte-addressed, word-aligned read with misalignment/range error flag.
// Optional feature macro: INSMEM_PARITY_EN (adds an even-parity bit per stored word).
module insmem_stream #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic [ADDR_W-1:0]          load_base,
  input  logic [$clog2(DEPTH):0]     load_count,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  output logic                       load_ready,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err,
  input  logic                       read_en,
  input  logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          instruction,
  output logic                       instr_valid,
  output logic                       fetch_err,
  output logic                       parity_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
`ifdef INSMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              load_err_q, load_err_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              parity_err_q, parity_err_d;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              base_bad;
  logic              fetch_bad;
  logic              wr_en;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  // Session validity: misaligned base or a window running past the last word is rejected.
  // The sum is one bit wider than the address so a huge base cannot wrap into range.
  assign base_bad  = (load_base[1:0] != 2'b00) ||
                     (({1'b0, (load_base >> 2)} + (ADDR_W+1)'(load_count)) > (ADDR_W+1)'(DEPTH));
  assign fetch_bad = (addr[1:0] != 2'b00) || ((addr >> 2) >= ADDR_W'(DEPTH));

  assign load_ready = (state_q == ST_LOAD);
  assign load_busy  = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign load_done  = (state_q == ST_DONE);
  assign load_err   = load_err_q;
  assign wr_en      = (state_q == ST_LOAD) && load_valid;

`ifdef INSMEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  // Loader FSM: validates the session, then walks the pointer once per accepted word.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    load_err_d  = load_err_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (base_bad) begin
            load_err_d = 1'b1;
          end else if (load_count == '0) begin
            load_err_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            load_err_d  = 1'b0;
            ptr_d       = load_base[IDX_W+1:2];
            remaining_d = load_count;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch path: the index is only meaningful once the address passed the range check.
  always_comb begin
    rd_word       = mem[addr[IDX_W+1:2]];
    instruction_d = instruction_q;
    instr_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    if (read_en) begin
      if (load_busy) begin
        // Fetches are blocked while a session owns the array.
        instruction_d = NOP_WORD;
      end else if (fetch_bad) begin
        instruction_d = NOP_WORD;
        instr_valid_d = 1'b1;
        fetch_err_d   = 1'b1;
      end else begin
        instruction_d = rd_word[DATA_W-1:0];
        instr_valid_d = 1'b1;
`ifdef INSMEM_PARITY_EN
        parity_err_d  = ^rd_word;
`endif
      end
    end
  end

  // Array write port: contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= wr_word;
  end

  // Control and fetch-output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      remaining_q   <= '0;
      load_err_q    <= 1'b0;
      instruction_q <= NOP_WORD;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      remaining_q   <= remaining_d;
      load_err_q    <= load_err_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
`ifdef INSMEM_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_insmem_stream.sv
// Testbench for insmem_stream: table-driven load sessions, hand sequences, randomized traffic
// checked against an array model of memory contents.
module tb_insmem_stream;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [31:0] load_base;
  logic [8:0]  load_count;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready, load_busy, load_done, load_err;
  logic        read_en;
  logic [31:0] addr;
  logic [31:0] instruction;
  logic        instr_valid, fetch_err, parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_wr  [DEPTH];

  typedef struct {
    logic [31:0] base;
    int          count;
    bit          exp_err;
    bit          block_reads;
  } start_vec_t;

  start_vec_t vecs [10];

  insmem_stream #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .read_en(read_en), .addr(addr), .instruction(instruction),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single fetch with read_en for one edge; expectation from the address rules and the model.
  task automatic do_fetch(input logic [31:0] a);
    read_en = 1'b1;
    addr    = a;
    tick();
    read_en = 1'b0;
    chk("fetch_valid", instr_valid, 1);
    if ((a % 4) != 0 || (a / 4) >= DEPTH) begin
      chk("fetch_nop", instruction, NOP);
      chk("fetch_err_bad", fetch_err, 1);
      chk("fetch_perr_bad", parity_err, 0);
    end else begin
      chk("fetch_err_ok", fetch_err, 0);
      if (model_wr[a / 4]) begin
        chk("fetch_data", instruction, model_mem[a / 4]);
        chk("fetch_perr", parity_err, 0);
      end
    end
    $display("fetch addr=%0h instr=%0h valid=%0b ferr=%0b", a, instruction, instr_valid, fetch_err);
  endtask

  // One load session with random valid gaps; optionally hammers the fetch port while busy.
  task automatic do_session(input logic [31:0] base, input int count, input bit exp_err,
                            input bit block_reads);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    logic [31:0] d;
    load_base  = base;
    load_count = 9'(count);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_err", load_err, exp_err);
    if (exp_err) begin
      chk("err_busy", load_busy, 0);
      chk("err_ready", load_ready, 0);
      tick();
      chk("err_sticky", load_err, 1);
      chk("err_idle_busy", load_busy, 0);
    end else if (count == 0) begin
      chk("zero_busy", load_busy, 1);
      chk("zero_done", load_done, 1);
      chk("zero_ready", load_ready, 0);
      tick();
      chk("zero_done_end", load_done, 0);
      chk("zero_busy_end", load_busy, 0);
    end else begin
      chk("sess_ready", load_ready, 1);
      chk("sess_busy", load_busy, 1);
      chk("sess_done0", load_done, 0);
      while (sent < count && cyc < 4 * count + 20) begin
        acc        = ($urandom % 4) != 0;
        d          = $urandom;
        load_valid = acc;
        load_data  = d;
        if (block_reads) begin
          read_en = 1'b1;
          addr    = 32'($urandom_range(0, DEPTH - 1)) * 4;
        end
        tick();
        cyc++;
        if (acc) begin
          model_mem[base / 4 + sent] = d;
          model_wr[base / 4 + sent]  = 1'b1;
          sent++;
        end
        if (block_reads) begin
          chk("blocked_valid", instr_valid, 0);
          chk("blocked_nop", instruction, NOP);
        end
        if (sent < count) begin
          chk("stream_ready", load_ready, 1);
          chk("stream_done", load_done, 0);
        end
      end
      load_valid = 1'b0;
      chk("session_words", sent, count);
      chk("done_pulse", load_done, 1);
      chk("done_ready", load_ready, 0);
      chk("done_busy", load_busy, 1);
      tick();
      if (block_reads) chk("blocked_done_valid", instr_valid, 0);
      read_en = 1'b0;
      chk("done_end", load_done, 0);
      chk("idle_busy", load_busy, 0);
    end
    $display("session base=%0h count=%0d err=%0b", base, count, load_err);
  endtask

  initial begin
    logic [31:0] prog [3];
    logic [31:0] a;
    int w, cnt;
    bit e;

    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_000A;
    prog[2] = 32'h200A_000F;
    for (int i = 0; i < DEPTH; i++) model_wr[i] = 1'b0;

    vecs[0] = '{32'd2,             1,     1'b1, 1'b0};
    vecs[1] = '{32'(4*(DEPTH-1)),  2,     1'b1, 1'b0};
    vecs[2] = '{32'(4*(DEPTH-1)),  1,     1'b0, 1'b1};
    vecs[3] = '{32'd40,            0,     1'b0, 1'b0};
    vecs[4] = '{32'd800,           57,    1'b1, 1'b0};
    vecs[5] = '{32'd800,           56,    1'b0, 1'b1};
    vecs[6] = '{32'd1,             0,     1'b1, 1'b0};
    vecs[7] = '{32'(4*DEPTH),      0,     1'b0, 1'b0};
    vecs[8] = '{32'd0,             DEPTH, 1'b0, 1'b0};
    vecs[9] = '{32'hFFFF_FFFC,     1,     1'b1, 1'b0};

    reset = 1'b0; load_start = 1'b0; load_base = '0; load_count = '0;
    load_valid = 1'b0; load_data = '0; read_en = 1'b0; addr = '0;

    // Reset values
    #3;
    chk("rst_instr", instruction, NOP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_ferr", fetch_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    tick();
    reset = 1'b1;
    tick();

    // Three-word program with one valid gap
    load_base = 32'd0; load_count = 9'd3; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("p_err", load_err, 0);
    chk("p_ready", load_ready, 1);
    load_valid = 1'b1; load_data = prog[0];
    tick();
    load_valid = 1'b0;
    tick();
    chk("p_gap_ready", load_ready, 1);
    chk("p_gap_done", load_done, 0);
    load_valid = 1'b1; load_data = prog[1];
    tick();
    load_data = prog[2];
    tick();
    load_valid = 1'b0;
    chk("p_done", load_done, 1);
    tick();
    chk("p_done_end", load_done, 0);
    chk("p_busy_end", load_busy, 0);
    for (int i = 0; i < 3; i++) begin
      model_mem[i] = prog[i];
      model_wr[i]  = 1'b1;
    end
    $display("program load done");

    // Back-to-back fetch with 1-cycle latency, then hold
    read_en = 1'b1; addr = 32'd0;
    #2;
    chk("lat_before", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      tick();
      chk("lat_data", instruction, prog[i]);
      chk("lat_valid", instr_valid, 1);
      $display("fetch addr=%0h instr=%0h", addr, instruction);
    end
    read_en = 1'b0;
    tick();
    chk("hold_valid", instr_valid, 0);
    chk("hold_instr", instruction, prog[2]);

    // Fetch errors
    do_fetch(32'(4 * DEPTH));
    do_fetch(32'd6);
    do_fetch(32'hFFFF_FFFC);
    do_fetch(32'(4 * DEPTH - 4));

    // Reset in the middle of a session
    do_fetch(32'd4);
    load_base = 32'd80; load_count = 9'd5; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_data = 32'hA5A5_0000 + 32'(i);
      tick();
      model_mem[20 + i] = load_data;
      model_wr[20 + i]  = 1'b1;
    end
    load_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", load_busy, 0);
    chk("mid_rst_ready", load_ready, 0);
    chk("mid_rst_done", load_done, 0);
    chk("mid_rst_err", load_err, 0);
    chk("mid_rst_instr", instruction, NOP);
    chk("mid_rst_valid", instr_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    do_fetch(32'd80);
    do_fetch(32'd84);
    $display("mid-load reset done");

    // Table of load sessions
    for (int i = 0; i < 10; i++)
      do_session(vecs[i].base, vecs[i].count, vecs[i].exp_err, vecs[i].block_reads);
    for (int i = 0; i < 8; i++) do_fetch(32'($urandom_range(0, DEPTH - 1)) * 4);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom % 3 == 0) begin
        w   = $urandom_range(0, DEPTH - 1);
        cnt = $urandom_range(0, 6);
        a   = 32'(w * 4 + (($urandom % 8 == 0) ? 2 : 0));
        e   = ((a % 4) != 0) || (w + cnt > DEPTH);
        do_session(a, cnt, e, 1'($urandom % 2));
      end else begin
        for (int k = 0; k < 4; k++) begin
          case ($urandom % 4)
            0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4000)) * 4;
            default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
          endcase
          do_fetch(a);
        end
      end
    end

`ifdef INSMEM_PARITY_EN
    // Corrupt one stored bit behind the loader's back
    dut.mem[1][3] = ~dut.mem[1][3];
    model_mem[1]  = model_mem[1] ^ 32'h8;
    read_en = 1'b1; addr = 32'd4;
    tick();
    read_en = 1'b0;
    chk("par_flag", parity_err, 1);
    chk("par_data", instruction, model_mem[1]);
    chk("par_valid", instr_valid, 1);
    $display("parity fetch addr=4 perr=%0b", parity_err);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
